parity_uart_rx: RTL

Serial asynchronous receiver with parity checking. It deserialises start/data/parity/stop frames from a single-bit line and verifies parity with the same XOR reduction the design uses for parity generation. It is the receiving end of the XOR-parity serial link and sits between an external RXD pin and a byte-wide consumer. Each frame yields one data word plus parity-error and framing-error flags.

---
 rtl/parity_uart_pkg.sv | 25 ++
 rtl/rx_sync.sv | 25 ++
 rtl/parity_uart_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/parity_uart_pkg.sv
// Shared types and helpers for the XOR-parity serial link.
// Holds receiver states, default sizing and the parity function.
package parity_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int PAR_MAX_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Same reduction the transmitter uses to generate the parity bit.
  function automatic logic xor_parity(
    input logic [PAR_MAX_W-1:0] data,
    input logic                 odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Ports: clk, rst_n (async, low), d (async in), q (synced, resets to 1).
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/parity_uart_rx.sv
// Serial receiver: start/data/parity/stop framing with parity check.
// Ports: clk, rst_n, rxd in; dout, dvalid, perr, ferr, busy out.
module parity_uart_rx
  import parity_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic rxd_s;
  logic prev_q;
  logic start_edge;

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              dvalid_q, dvalid_d;

  rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Edge-qualified start: a line parked low never retriggers.
  assign start_edge = prev_q & ~rxd_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pend_d   = pend_q;
    dout_d   = dout_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    dvalid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_W-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          pend_d  = xor_parity(PAR_MAX_W'(shift_q),
                               PARITY_ODD) ^ rxd_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          dvalid_d = 1'b1;
          dout_d   = shift_q;
          perr_d   = pend_q;
          ferr_d   = ~rxd_s;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pend_q   <= 1'b0;
      dout_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      prev_q   <= rxd_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      dout_q   <= dout_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign perr   = perr_q;
  assign ferr   = ferr_q;
  assign busy   = (state_q != S_IDLE);

endmodule
